// File: rtl/frequency_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM states and BCD converter constants.
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;

endpackage

// File: rtl/frequency_meter_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a registered rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic edge_p
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            edge_p <= 1'b0;
        end else begin
            s1     <= sig_in;
            s2     <= s1;
            s3     <= s2;
            edge_p <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/frequency_meter.sv
// Counts sig_in rising edges over a GATE_CYCLES window and publishes one count per window.
// Define FREQ_METER_BCD_EN to add a sequential double-dabble BCD copy of the result.
module frequency_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 16,
    parameter int DIGITS      = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sig_in,
    input  logic                          enable,
    output logic [CNT_W-1:0]              freq_out,
    output logic                          freq_valid,
`ifdef FREQ_METER_BCD_EN
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          bcd_valid,
`endif
    output logic                          overflow
);

    localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat;
    logic             edge_p;
    logic             at_max;

    sync_edge_detect u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .edge_p (edge_p)
    );

    assign at_max = (edge_cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = GATE;
            GATE:    if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_out   <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            freq_valid <= 1'b0;
            if (state != GATE || !enable) begin
                // leaving the window discards the partial count
                win_cnt  <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (win_cnt == WIN_LAST) begin
                // include an edge landing on the terminal cycle, restart with no dead cycle
                freq_out   <= (edge_p && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
                overflow   <= sat | (edge_p & at_max);
                freq_valid <= 1'b1;
                win_cnt    <= '0;
                edge_cnt   <= '0;
                sat        <= 1'b0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (edge_p) begin
                    if (at_max) sat <= 1'b1;
                    else        edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FREQ_METER_BCD_EN
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int BIT_W = $clog2(CNT_W + 1);

    logic [BCD_W-1:0] bcd_acc, bcd_adj;
    logic [CNT_W-1:0] bin_sr;
    logic [BIT_W-1:0] bit_cnt;
    logic             busy;

    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_DIGIT_W'(ADD3_THRESH))
                bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    bcd_acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_acc   <= '0;
            bin_sr    <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (freq_valid) begin
                bcd_acc <= '0;
                bin_sr  <= freq_out;
                bit_cnt <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[CNT_W-1]};
                bin_sr  <= bin_sr << 1;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == BIT_W'(CNT_W - 1)) begin
                    busy      <= 1'b0;
                    bcd_out   <= {bcd_adj[BCD_W-2:0], bin_sr[CNT_W-1]};
                    bcd_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/frequency_meter.md
# frequency_meter

Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of system-clock cycles, and publishes one count per window. It is the measuring counterpart of the panel's frequency divider: the divider derives slow rates from `clk`, this block recovers a rate from a slow signal. It sits between an external input pin or any divided-clock net and the panel's display logic.

## Interface
- `GATE_CYCLES`, 50_000_000, gate window length in `clk` cycles (1 s at 50 MHz); must be ≥ `CNT_W`+4
- `CNT_W`, 16, edge-counter and result width
- `DIGITS`, 5, BCD digits produced when BCD output is compiled in; 10^DIGITS must exceed 2^CNT_W−1
- `clk` input 1 system clock; all logic is on its rising edge
- `reset` input 1 synchronous, active-high reset
- `sig_in` input 1 measured signal, asynchronous to `clk`
- `enable` input 1 level; high runs back-to-back windows, low idles
- `freq_out` output CNT_W rising edges counted in the last completed window
- `freq_valid` output 1 one-cycle pulse when `freq_out` updates
- `overflow` output 1 high when the last completed window saturated; updates with `freq_valid`
- `bcd_out` output 4*DIGITS BCD of `freq_out`, LS digit in bits [3:0] (only with `FREQ_METER_BCD_EN`)
- `bcd_valid` output 1 one-cycle pulse when `bcd_out` updates (only with `FREQ_METER_BCD_EN`)

## Operation
- `sig_in` passes a 2-flop synchronizer, then a rising-edge detector producing a one-cycle `edge_p`.
- FSM states: `IDLE`, `GATE`.
  - `IDLE`: window counter and edge counter held at 0. `enable`=1 → `GATE`.
  - `GATE`: window counter counts 0..GATE_CYCLES−1; `edge_p` increments edge counter. `enable`=0 → `IDLE`, partial count discarded, no `freq_valid`.
  - Terminal window cycle (window counter = GATE_CYCLES−1): `freq_out` ← edge counter + `edge_p` (saturating), `overflow` ← saturation flag, `freq_valid` pulses next cycle; both counters restart at 0 with no dead cycle; stay in `GATE`.
- Edge counter saturates at 2^CNT_W−1; further edges set an internal sticky saturation flag, cleared at window restart.
- Edge detector keeps running in `IDLE` so a level already high at enable is not counted as an edge.
- `reset`: FSM → `IDLE`; synchronizer flops, counters, `freq_out`, `overflow`, `freq_valid`, `bcd_out`, `bcd_valid` all 0.
- `reset` mid-window or mid-conversion aborts it; no valid pulse is produced.

## Timing
- `sig_in` rising edge → `edge_p` 3 `clk` cycles later (2 sync + 1 detect).
- `enable` first sampled high at cycle N → `GATE` from N+1 → first `freq_valid` at cycle N+1+GATE_CYCLES; subsequent pulses every GATE_CYCLES cycles.
- `freq_out`/`overflow` change only in the cycle `freq_valid` is high and hold otherwise, including through `IDLE`.
- Minimum measurable `sig_in` high and low time: 2 `clk` cycles; shorter pulses may be missed.
- BCD conversion: starts the cycle after `freq_valid`, takes CNT_W cycles, `bcd_valid` pulses CNT_W+1 cycles after `freq_valid`; `bcd_out` holds between updates.

## Configuration
- `FREQ_METER_BCD_EN` defined: `bcd_out`/`bcd_valid` ports and a sequential shift-add-3 (double-dabble) converter are built; one bit per cycle.
- Undefined: ports and converter absent; binary `freq_out` only; all other behaviour identical.

## Structure
- Package `freq_meter_pkg`: FSM state enum (`IDLE`, `GATE`), BCD digit width constant (4), add-3 threshold constant (5).
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rising-edge pulse, clocked by `clk`, reset by `reset`.
- BCD converter stays inline under the macro.

## Test plan
- Bench: GATE_CYCLES=100, CNT_W=8, DIGITS=3, `FREQ_METER_BCD_EN` defined unless noted.
- Assert `reset` 3 cycles with `sig_in` toggling → all outputs 0; no `freq_valid` while `enable`=0.
- `sig_in` period 10 clk (5 high/5 low), `enable` high → `freq_out`=10, `overflow`=0, `freq_valid` every 100 cycles, first at N+101.
- `sig_in` period 4 clk → 25 per window; instance CNT_W=4 → `freq_out`=15, `overflow`=1.
- `enable` dropped 50 cycles into a window → no `freq_valid`, `freq_out` holds 10; re-enable → next pulse 101 cycles after enable sampled.
- `sig_in` held high through enable → `freq_out`=0 every window.
- `freq_out`=25 → `bcd_out`=12'h025 with `bcd_valid` 9 cycles after `freq_valid`; macro undefined build compiles without BCD ports.
